// File: rtl/boot_rom_ctrl_if.sv
// ---------------------------------------------------------------------------
// boot_rom_ctrl_if
// Read-bus bundle between the CPU side (master) and the boot ROM (slave).
//   addr        master -> slave   read address, sampled with rd_en
//   rd_en       master -> slave   read request, one word per cycle
//   unmap       master -> slave   one-cycle strobe, retires the ROM until reset
//   bus_out     slave  -> master  read data, zero whenever rd_valid is low
//   rd_valid    slave  -> master  bus_out carries the word requested last cycle
//   ready       slave  -> master  self-test finished, reads are accepted
//   sum_ok      slave  -> master  boot image checksum matched (sticky)
//   rom_active  slave  -> master  ROM is mapped and answers reads
// ---------------------------------------------------------------------------
interface boot_rom_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic              unmap;
  logic [DATA_W-1:0] bus_out;
  logic              rd_valid;
  logic              ready;
  logic              sum_ok;
  logic              rom_active;

  modport master (
    output addr, rd_en, unmap,
    input  bus_out, rd_valid, ready, sum_ok, rom_active
  );

  modport slave (
    input  addr, rd_en, unmap,
    output bus_out, rd_valid, ready, sum_ok, rom_active
  );
endinterface

// File: rtl/boot_rom_ctrl.sv
// ---------------------------------------------------------------------------
// boot_rom_ctrl
// Boot ROM for the AS2650 SoC. Serves the boot program with one-cycle
// registered reads, drives zero when idle so it can be OR-combined onto the
// CPU read bus, and can be unmapped by software after boot.
//
// Optional feature macro: BOOT_ROM_SELFTEST_EN
//   defined   : SCAN/DONE power-on checksum over all DEPTH words; ready rises
//               DEPTH edges after reset release, sum_ok reports the compare.
//   undefined : no scan; ready and sum_ok rise one edge after reset release.
//
// Ports
//   clk_i   system clock, rising edge
//   rst     asynchronous reset, active-high
//   bus     boot_rom_ctrl_if.slave (addr, rd_en, unmap / bus_out, rd_valid,
//           ready, sum_ok, rom_active)
//
// The ROM image is given by INIT_IMAGE, word 0 in the most significant
// DATA_W bits. Words at addresses >= DEPTH read as zero.
// ---------------------------------------------------------------------------
module boot_rom_ctrl #(
  parameter int                       DATA_W     = 8,
  parameter int                       ADDR_W     = 8,
  parameter int                       DEPTH      = 170,
  parameter logic [DEPTH*DATA_W-1:0]  INIT_IMAGE = {(DEPTH*DATA_W){1'b0}},
  parameter logic [DATA_W-1:0]        EXP_SUM    = {DATA_W{1'b0}}
) (
  input  logic           clk_i,
  input  logic           rst,
  boot_rom_ctrl_if.slave bus
);

  // Full address window; unpopulated words are tied to zero so the CPU read
  // path needs no separate range compare.
  logic [DATA_W-1:0] mem_s [2**ADDR_W];

  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_mem
    if (i < DEPTH) begin : g_pop
      assign mem_s[i] = INIT_IMAGE[(DEPTH-1-i)*DATA_W +: DATA_W];
    end else begin : g_zero
      assign mem_s[i] = {DATA_W{1'b0}};
    end
  end

  logic [DATA_W-1:0] bus_out_q;
  logic              rd_valid_q;
  logic              rom_active_q;
  logic              ready_q;
  logic              sum_ok_q;
  logic              accept_s;

  assign accept_s = bus.rd_en & ready_q & rom_active_q;

  // CPU read port and unmap latch; a read issued together with unmap is
  // still served because rom_active_q only drops at that edge.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      bus_out_q    <= {DATA_W{1'b0}};
      rd_valid_q   <= 1'b0;
      rom_active_q <= 1'b1;
    end else begin
      rd_valid_q <= accept_s;
      bus_out_q  <= accept_s ? mem_s[bus.addr] : {DATA_W{1'b0}};
      if (bus.unmap) begin
        rom_active_q <= 1'b0;
      end
    end
  end

`ifdef BOOT_ROM_SELFTEST_EN
  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_SCAN = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] sum_s;

  // Scan uses its own read port into the image, independent of bus.addr.
  assign sum_s = acc_q + mem_s[ADDR_W'(ptr_q)];

  // Self-test FSM: accumulate every populated word, then compare once.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SCAN;
      ptr_q    <= {PTR_W{1'b0}};
      acc_q    <= {DATA_W{1'b0}};
      ready_q  <= 1'b0;
      sum_ok_q <= 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          acc_q <= sum_s;
          ptr_q <= ptr_q + PTR_W'(1);
          if (ptr_q == LAST_PTR) begin
            state_q  <= ST_DONE;
            ready_q  <= 1'b1;
            sum_ok_q <= (sum_s == EXP_SUM);
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end
`else
  // No checksum hardware in this build; the expected sum has no consumer.
  logic unused_exp_sum_s;
  assign unused_exp_sum_s = ^EXP_SUM;

  // Without a scan the ROM is usable on the first edge after reset release.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      sum_ok_q <= 1'b0;
    end else begin
      ready_q  <= 1'b1;
      sum_ok_q <= 1'b1;
    end
  end
`endif

  assign bus.bus_out    = bus_out_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.ready      = ready_q;
  assign bus.sum_ok     = sum_ok_q;
  assign bus.rom_active = rom_active_q;

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// ---------------------------------------------------------------------------
// tb_boot_rom_ctrl
// Directed bench for boot_rom_ctrl with a 4-word image C0 C0 1B 05.
// dut_a expects checksum 8'hA0 (matches), dut_b expects 8'hA1 (mismatch).
// Outputs are sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_boot_rom_ctrl;

`ifdef BOOT_ROM_SELFTEST_EN
  localparam int  RDY_EDGES = 4;
  localparam logic SUM_OK_B = 1'b0;
`else
  localparam int  RDY_EDGES = 1;
  localparam logic SUM_OK_B = 1'b1;
`endif

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   failed;

  boot_rom_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifa ();
  boot_rom_ctrl_if #(.DATA_W(8), .ADDR_W(8)) ifb ();

  boot_rom_ctrl #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(4),
    .INIT_IMAGE(32'hC0C0_1B05), .EXP_SUM(8'hA0)
  ) dut_a (
    .clk_i(clk), .rst(rst), .bus(ifa.slave)
  );

  boot_rom_ctrl #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(4),
    .INIT_IMAGE(32'hC0C0_1B05), .EXP_SUM(8'hA1)
  ) dut_b (
    .clk_i(clk), .rst(rst), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".bus_out"},    {24'd0, ifa.bus_out}, 32'h0);
    chk({tag, ".rd_valid"},   {31'd0, ifa.rd_valid}, 32'h0);
    chk({tag, ".ready"},      {31'd0, ifa.ready}, 32'h0);
    chk({tag, ".sum_ok"},     {31'd0, ifa.sum_ok}, 32'h0);
    chk({tag, ".rom_active"}, {31'd0, ifa.rom_active}, 32'h1);
  endtask

  logic [7:0] burst_addr [6];
  logic [7:0] burst_exp  [6];

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    burst_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
    burst_exp  = '{8'hC0, 8'hC0, 8'h1B, 8'h05, 8'h00, 8'h00};

    rst = 1'b1;
    ifa.addr = 8'h00; ifa.rd_en = 1'b0; ifa.unmap = 1'b0;
    ifb.addr = 8'h00; ifb.rd_en = 1'b0; ifb.unmap = 1'b0;
    step();
    step();
    chk_reset_a("reset");

    // Release with a read of addr 3 pending on dut_a: rejected until ready.
    rst = 1'b0;
    ifa.rd_en = 1'b1;
    ifa.addr  = 8'h03;
    for (int e = 1; e <= RDY_EDGES; e++) begin
      step();
      chk($sformatf("scan_e%0d.ready", e), {31'd0, ifa.ready}, {31'd0, (e == RDY_EDGES)});
      chk($sformatf("scan_e%0d.rd_valid", e), {31'd0, ifa.rd_valid}, 32'h0);
      chk($sformatf("scan_e%0d.bus_out", e), {24'd0, ifa.bus_out}, 32'h0);
      chk($sformatf("scan_e%0d.b_rd_valid", e), {31'd0, ifb.rd_valid}, 32'h0);
    end
    ifa.rd_en = 1'b0;
    chk("done.sum_ok_a", {31'd0, ifa.sum_ok}, 32'h1);
    chk("done.sum_ok_b", {31'd0, ifb.sum_ok}, {31'd0, SUM_OK_B});
    chk("done.ready_b",  {31'd0, ifb.ready}, 32'h1);

    // Bad checksum does not block reads.
    ifb.rd_en = 1'b1;
    ifb.addr  = 8'h02;
    step();
    ifb.rd_en = 1'b0;
    chk("b_read2.bus_out",  {24'd0, ifb.bus_out}, 32'h1B);
    chk("b_read2.rd_valid", {31'd0, ifb.rd_valid}, 32'h1);

    // Back-to-back burst including out-of-range addresses.
    for (int i = 0; i < 6; i++) begin
      ifa.rd_en = 1'b1;
      ifa.addr  = burst_addr[i];
      step();
      chk($sformatf("burst%0d.bus_out", i), {24'd0, ifa.bus_out}, {24'd0, burst_exp[i]});
      chk($sformatf("burst%0d.rd_valid", i), {31'd0, ifa.rd_valid}, 32'h1);
    end
    ifa.rd_en = 1'b0;
    step();
    chk("idle.bus_out",  {24'd0, ifa.bus_out}, 32'h0);
    chk("idle.rd_valid", {31'd0, ifa.rd_valid}, 32'h0);

    // Read in the same cycle as unmap is served; the next one is rejected.
    ifa.rd_en = 1'b1;
    ifa.addr  = 8'h03;
    ifa.unmap = 1'b1;
    step();
    ifa.unmap = 1'b0;
    chk("unmap_rd.bus_out",    {24'd0, ifa.bus_out}, 32'h05);
    chk("unmap_rd.rd_valid",   {31'd0, ifa.rd_valid}, 32'h1);
    chk("unmap_rd.rom_active", {31'd0, ifa.rom_active}, 32'h0);
    ifa.addr = 8'h00;
    step();
    ifa.rd_en = 1'b0;
    chk("post_unmap.bus_out",    {24'd0, ifa.bus_out}, 32'h0);
    chk("post_unmap.rd_valid",   {31'd0, ifa.rd_valid}, 32'h0);
    chk("post_unmap.rom_active", {31'd0, ifa.rom_active}, 32'h0);

    // Reset restores mapping; then reset again at scan edge 2.
    rst = 1'b1;
    step();
    chk_reset_a("rst2");
    rst = 1'b0;
    step();
    step();
    chk("mid_scan_e2.ready", {31'd0, ifa.ready}, {31'd0, (RDY_EDGES <= 2)});
    rst = 1'b1;
    #1;
    chk_reset_a("rst_mid_scan");
    step();
    rst = 1'b0;
    for (int e = 1; e <= RDY_EDGES; e++) begin
      step();
      chk($sformatf("rescan_e%0d.ready", e), {31'd0, ifa.ready}, {31'd0, (e == RDY_EDGES)});
    end

    // Reset arriving with an accepted read: nothing is returned.
    ifa.rd_en = 1'b1;
    ifa.addr  = 8'h01;
    rst = 1'b1;
    step();
    chk("rst_rd.rd_valid", {31'd0, ifa.rd_valid}, 32'h0);
    chk("rst_rd.bus_out",  {24'd0, ifa.bus_out}, 32'h0);
    ifa.rd_en = 1'b0;
    rst = 1'b0;
    for (int e = 1; e <= RDY_EDGES; e++) begin
      step();
    end
    chk("final.ready", {31'd0, ifa.ready}, 32'h1);

    // Single read of addr 1 with one-cycle latency.
    ifa.rd_en = 1'b1;
    ifa.addr  = 8'h01;
    step();
    ifa.rd_en = 1'b0;
    chk("final_rd1.bus_out",  {24'd0, ifa.bus_out}, 32'hC0);
    chk("final_rd1.rd_valid", {31'd0, ifa.rd_valid}, 32'h1);
    step();
    chk("final_idle.rd_valid", {31'd0, ifa.rd_valid}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
